// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-outstanding valid/ready command to APB3/APB4 SETUP/ACCESS initiator.
// Optional build macro APB_MASTER_TIMEOUT_EN aborts an ACCESS phase after TIMEOUT_CYCLES wait states.
module apb_master_bridge #(
    parameter int PDATA_SIZE     = 32,
    parameter int PADDR_SIZE     = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      APB_CLK,
    input  logic                      APB_RESET_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [PADDR_SIZE-1:0]     cmd_addr,
    input  logic [PDATA_SIZE-1:0]     cmd_wdata,
    input  logic [PDATA_SIZE/8-1:0]   cmd_strb,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [PDATA_SIZE-1:0]     rsp_rdata,
    output logic                      rsp_err,
    output logic                      APB_PSEL,
    output logic                      APB_PENABLE,
    output logic [PADDR_SIZE-1:0]     APB_PADDR,
    output logic                      APB_PWRITE,
    output logic [PDATA_SIZE/8-1:0]   APB_PSTRB,
    output logic [PDATA_SIZE-1:0]     APB_PWDATA,
    input  logic [PDATA_SIZE-1:0]     APB_PRDATA,
    input  logic                      APB_PREADY,
    input  logic                      APB_PSLVERR
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t state;

    if (PDATA_SIZE % 8 != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("apb_master_bridge: PDATA_SIZE must be a multiple of 8 and TIMEOUT_CYCLES >= 1");
    end

    assign cmd_ready = state == IDLE;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wait_cnt;
    logic          expired;

    // the current wait cycle is the one that brings the count to the limit
    assign expired = wait_cnt == CW'(TIMEOUT_CYCLES - 1);
`endif

    // transfer sequencer; every APB and response output is a register of this block
    always_ff @(posedge APB_CLK or negedge APB_RESET_n) begin
        if (!APB_RESET_n) begin
            state       <= IDLE;
            APB_PSEL    <= 1'b0;
            APB_PENABLE <= 1'b0;
            APB_PADDR   <= '0;
            APB_PWRITE  <= 1'b0;
            APB_PSTRB   <= '0;
            APB_PWDATA  <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
            wait_cnt    <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    APB_PADDR  <= cmd_addr;
                    APB_PWRITE <= cmd_write;
                    APB_PWDATA <= cmd_wdata;
                    APB_PSTRB  <= cmd_write ? cmd_strb : '0;
                    APB_PSEL   <= 1'b1;
                    state      <= SETUP;
                end
                SETUP: begin
                    APB_PENABLE <= 1'b1;
                    state       <= ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
                    wait_cnt    <= '0;
`endif
                end
                ACCESS: if (APB_PREADY) begin
                    rsp_rdata   <= APB_PWRITE ? '0 : APB_PRDATA;
                    rsp_err     <= APB_PSLVERR;
                    rsp_valid   <= 1'b1;
                    APB_PSEL    <= 1'b0;
                    APB_PENABLE <= 1'b0;
                    state       <= RESP;
                end
`ifdef APB_MASTER_TIMEOUT_EN
                else if (expired) begin
                    rsp_rdata   <= '0;
                    rsp_err     <= 1'b1;
                    rsp_valid   <= 1'b1;
                    APB_PSEL    <= 1'b0;
                    APB_PENABLE <= 1'b0;
                    state       <= RESP;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
`endif
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: randomized scoreboard bench with an APB completer memory model for apb_master_bridge.
module tb_apb_master_bridge;
    localparam int DW = 32;
    localparam int AW = 4;
    localparam int SW = DW / 8;
    localparam int T  = 4;
`ifdef APB_MASTER_TIMEOUT_EN
    localparam bit TO = 1'b1;
`else
    localparam bit TO = 1'b0;
`endif

    typedef struct {
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [SW-1:0] s;
        logic [DW-1:0] er;
        logic          ee;
        int            eff;
    } cmd_t;

    typedef struct {
        int   waits;
        logic err;
    } plan_t;

    logic          APB_CLK = 1'b0;
    logic          APB_RESET_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [SW-1:0] cmd_strb = '0;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] APB_PRDATA = '0;
    logic          APB_PREADY = 1'b0;
    logic          APB_PSLVERR = 1'b0;
    logic          cmd_ready, rsp_valid, rsp_err;
    logic [DW-1:0] rsp_rdata, APB_PWDATA;
    logic          APB_PSEL, APB_PENABLE, APB_PWRITE;
    logic [AW-1:0] APB_PADDR;
    logic [SW-1:0] APB_PSTRB;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int hold_left = 0;

    cmd_t  cmd_q[$];
    plan_t plan_q[$];
    logic [DW-1:0] ref_mem [16];
    logic [DW-1:0] slv_mem [16];

    apb_master_bridge #(.PDATA_SIZE(DW), .PADDR_SIZE(AW), .TIMEOUT_CYCLES(T)) dut (
        .APB_CLK(APB_CLK), .APB_RESET_n(APB_RESET_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .APB_PSEL(APB_PSEL), .APB_PENABLE(APB_PENABLE), .APB_PADDR(APB_PADDR),
        .APB_PWRITE(APB_PWRITE), .APB_PSTRB(APB_PSTRB), .APB_PWDATA(APB_PWDATA),
        .APB_PRDATA(APB_PRDATA), .APB_PREADY(APB_PREADY), .APB_PSLVERR(APB_PSLVERR)
    );

    always #5 APB_CLK = ~APB_CLK;

    always @(posedge APB_CLK) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    // reference write merge: byte mask built from the strobes
    function automatic logic [DW-1:0] ref_merge(input logic [DW-1:0] old, input logic [DW-1:0] d, input logic [SW-1:0] s);
        logic [DW-1:0] m;
        m = '0;
        for (int i = 0; i < SW; i++) m |= {{(DW-8){1'b0}}, {8{s[i]}}} << (8 * i);
        return (old & ~m) | (d & m);
    endfunction

    // completer model: per-transfer wait/error plan, memory behind the bus, noise when not completing
    plan_t pl = '{0, 1'b0};
    int acnt = 0;
    always @(negedge APB_CLK) begin
        if (APB_PSEL && !APB_PENABLE) begin
            acnt = 0;
            if (plan_q.size() != 0) pl = plan_q.pop_front();
        end
        if (APB_PSEL && APB_PENABLE) begin
            APB_PREADY = acnt >= pl.waits;
            acnt++;
            APB_PSLVERR = APB_PREADY ? pl.err : 1'b1;
            APB_PRDATA = (APB_PREADY && !APB_PWRITE) ? slv_mem[APB_PADDR] : $urandom;
            if (APB_PREADY && APB_PWRITE && !pl.err)
                for (int i = 0; i < SW; i++)
                    if (APB_PSTRB[i]) slv_mem[APB_PADDR][8*i +: 8] = APB_PWDATA[8*i +: 8];
        end else begin
            APB_PREADY = 1'($urandom);
            APB_PSLVERR = 1'($urandom);
            APB_PRDATA = $urandom;
        end
    end

    // response consumer: mostly ready, with a directed hold window
    always @(posedge APB_CLK) begin
        #1;
        if (hold_left > 0) begin
            rsp_ready = 1'b0;
            if (rsp_valid) hold_left--;
        end else begin
            rsp_ready = $urandom_range(0, 3) != 0;
        end
    end

    // monitor: phase-by-phase check of the transfer against the popped expectation
    bit   active = 0;
    bit   holding = 0;
    int   acc_edge = 0;
    int   d;
    cmd_t cur;
    always @(negedge APB_CLK) begin
        if (!APB_RESET_n) begin
            active = 0;
            holding = 0;
        end else begin
            if (active) begin
                d = cyc - acc_edge;
                chk("cmd_ready_busy", cmd_ready, 0);
                if (d <= 1 + cur.eff) begin
                    chk(d == 0 ? "setup_phase" : "access_phase", {APB_PSEL, APB_PENABLE}, d == 0 ? 2'b10 : 2'b11);
                    chk("paddr", APB_PADDR, cur.a);
                    chk("pwrite", APB_PWRITE, cur.w);
                    chk("pstrb", APB_PSTRB, cur.w ? cur.s : '0);
                    if (cur.w) chk("pwdata", APB_PWDATA, cur.d);
                    chk("rsp_early", rsp_valid, 0);
                end else begin
                    chk("rsp_valid_latency", rsp_valid, 1);
                    chk("psel_after", {APB_PSEL, APB_PENABLE}, 2'b00);
                    chk("rsp_rdata", rsp_rdata, cur.er);
                    chk("rsp_err", rsp_err, cur.ee);
                    active = 0;
                    holding = 1;
                end
            end else if (holding) begin
                chk("rsp_held", rsp_valid, 1);
                chk("rsp_rdata_held", rsp_rdata, cur.er);
                chk("rsp_err_held", rsp_err, cur.ee);
                chk("cmd_ready_resp", cmd_ready, 0);
                chk("bus_idle_resp", {APB_PSEL, APB_PENABLE}, 2'b00);
                chk("paddr_kept", APB_PADDR, cur.a);
                chk("pwrite_kept", APB_PWRITE, cur.w);
            end else begin
                chk("no_stale_rsp", rsp_valid, 0);
                chk("bus_idle", {APB_PSEL, APB_PENABLE}, 2'b00);
            end
            if (holding && rsp_valid && rsp_ready) holding = 0;
            if (cmd_valid && cmd_ready) begin
                chk("accept_when_idle", {active, holding}, 2'b00);
                if (cmd_q.size() == 0) begin
                    chk("spurious_accept", 1, 0);
                end else begin
                    cur = cmd_q.pop_front();
                    active = 1;
                    acc_edge = cyc + 1;
                end
            end
        end
    end

    // issue one command; expected response comes from the reference memory and the wait/error plan
    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] dd,
                         input logic [SW-1:0] s, input int waits, input logic err);
        cmd_t c;
        bit   to;
        to = TO && waits >= T;
        c.w = w;
        c.a = a;
        c.d = dd;
        c.s = s;
        c.eff = to ? T - 1 : waits;
        c.er = (w || to) ? '0 : ref_mem[a];
        c.ee = to || err;
        if (w && !to && !err) ref_mem[a] = ref_merge(ref_mem[a], dd, s);
        cmd_q.push_back(c);
        plan_q.push_back('{waits, err});
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr = a;
        cmd_wdata = dd;
        cmd_strb = s;
        for (int k = 0; ; k++) begin
            @(negedge APB_CLK);
            if (cmd_ready) break;
            if (k == 300) begin
                chk("accept_timeout", 0, 1);
                void'(cmd_q.pop_back());
                void'(plan_q.pop_back());
                cmd_valid = 1'b0;
                return;
            end
        end
        @(posedge APB_CLK);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 500; k++) begin
            @(negedge APB_CLK);
            if (!rsp_valid && !APB_PSEL && !active && !holding) break;
        end
        if (k == 500) chk("drain_timeout", 1, 0);
        @(posedge APB_CLK);
        #1;
    endtask

    task automatic reset_mid_transfer();
        #2;
        APB_RESET_n = 1'b0;
        #1;
        chk("async_reset_outputs", {APB_PSEL, APB_PENABLE, rsp_valid}, 3'b000);
        cmd_q.delete();
        plan_q.delete();
        repeat (2) @(posedge APB_CLK);
        #1;
        APB_RESET_n = 1'b1;
        @(negedge APB_CLK);
        chk("cmd_ready_after_reset", cmd_ready, 1);
        repeat (10) @(posedge APB_CLK);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ref_mem[i] = $urandom;
        ref_mem[3] = 32'h1234_5678;
        for (int i = 0; i < 16; i++) slv_mem[i] = ref_mem[i];
        repeat (3) @(posedge APB_CLK);
        #1;
        chk("reset_state", {rsp_valid, rsp_err, rsp_rdata, APB_PSEL, APB_PENABLE, APB_PADDR, APB_PWRITE, APB_PSTRB, APB_PWDATA}, '0);
        APB_RESET_n = 1'b1;
        @(posedge APB_CLK);
        #1;
        issue(1'b1, 4'h1, 32'hA5A5_0F0F, 4'hF, 0, 1'b0);
        issue(1'b0, 4'h3, $urandom, 4'hF, 3, 1'b0);
        issue(1'b1, 4'h5, $urandom, 4'b0011, 2, 1'b1);
        issue(1'b0, 4'h5, '0, '0, 0, 1'b0);
        issue(1'b0, 4'h1, '0, '0, 1, 1'b0);
        drain();
        hold_left = 5;
        issue(1'b1, 4'h7, $urandom, 4'b1010, 1, 1'b0);
        issue(1'b0, 4'h7, $urandom, 4'hF, 0, 1'b0);
        for (int n = 0; n < 200; n++)
            issue(1'($urandom), 4'($urandom), $urandom, 4'($urandom), $urandom_range(0, 5), $urandom_range(0, 7) == 0);
        drain();
        issue(1'b0, 4'h2, '0, '0, 1000, 1'b0);
        repeat (2) @(posedge APB_CLK);
        reset_mid_transfer();
        issue(1'b0, 4'h3, '0, '0, 0, 1'b0);
        drain();
        issue(1'b0, 4'h4, '0, '0, 1000, 1'b0);
`ifdef APB_MASTER_TIMEOUT_EN
        drain();
`else
        repeat (100) @(posedge APB_CLK);
        @(negedge APB_CLK);
        chk("still_in_access", {APB_PSEL, APB_PENABLE, rsp_valid}, 3'b110);
        @(posedge APB_CLK);
        reset_mid_transfer();
`endif
        issue(1'b1, 4'h9, $urandom, 4'hF, 0, 1'b0);
        drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
Single-outstanding APB initiator. It converts a simple valid/ready command interface into APB3/APB4 SETUP/ACCESS transfers. It sits between a local controller (CPU-side sequencer or test master) and APB completers such as the GPIO block. It honours PREADY wait states and returns read data and PSLVERR through a held response handshake.

Parameters:
PDATA_SIZE, 32, data bus width; must be a multiple of 8.
PADDR_SIZE, 4, APB address width.
TIMEOUT_CYCLES, 16, ACCESS wait-state limit; used only with the optional feature; must be ≥ 1.

Ports:
APB_CLK  in  1  clock; all logic on rising edge.
APB_RESET_n  in  1  asynchronous active-low reset.
cmd_valid  in  1  command request.
cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
cmd_write  in  1  1 = write, 0 = read.
cmd_addr  in  PADDR_SIZE  target address.
cmd_wdata  in  PDATA_SIZE  write data.
cmd_strb  in  PDATA_SIZE/8  byte strobes for writes.
rsp_valid  out  1  response available.
rsp_ready  in  1  response consumed when rsp_valid & rsp_ready.
rsp_rdata  out  PDATA_SIZE  read data; 0 for writes.
rsp_err  out  1  PSLVERR captured, or timeout when the optional feature is enabled.
APB_PSEL  out  1  completer select.
APB_PENABLE  out  1  access phase.
APB_PADDR  out  PADDR_SIZE  address.
APB_PWRITE  out  1  direction.
APB_PSTRB  out  PDATA_SIZE/8  strobes; all zero on reads.
APB_PWDATA  out  PDATA_SIZE  write data.
APB_PRDATA  in  PDATA_SIZE  read data from completer.
APB_PREADY  in  1  completer ready / wait-state control.
APB_PSLVERR  in  1  completer error.

Behaviour:
- Clock and reset: one clock, APB_CLK. APB_RESET_n is asynchronous and active-low. Reset clears all outputs to 0 and forces state to IDLE.
- Reset mid-transfer: the transfer is abandoned and no response is produced. APB_PSEL and APB_PENABLE drop to 0 immediately on assertion.
- All outputs are registered, except cmd_ready, which is decoded directly from state (state == IDLE).
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid: latch addr/write/wdata/strb into the APB output registers. APB_PSTRB is loaded with 0 when cmd_write = 0, and APB_PWDATA may hold cmd_wdata.
  - Set APB_PSEL = 1 and go to SETUP.
- SETUP: exactly one cycle with APB_PSEL = 1, APB_PENABLE = 0. Next state is ACCESS, with APB_PENABLE set to 1.
- ACCESS:
  - APB_PSEL = APB_PENABLE = 1. Address, control and data are held stable.
  - While APB_PREADY = 0: stay in ACCESS. There is no wait-state limit unless the optional feature is enabled.
  - When APB_PREADY = 1:
    - capture rsp_rdata = APB_PWRITE ? 0 : APB_PRDATA;
    - capture rsp_err = APB_PSLVERR;
    - set rsp_valid = 1;
    - clear APB_PSEL and APB_PENABLE;
    - go to RESP.
- RESP:
  - rsp_valid, rsp_rdata and rsp_err are held until rsp_ready = 1.
  - On that cycle clear rsp_valid and go to IDLE.
  - cmd_ready stays 0 throughout RESP, so back-to-back commands have at least one IDLE cycle between transfers.
- Latency:
  - Command accepted at edge N.
  - SETUP is visible in cycle N+1 and ACCESS in cycle N+2.
  - With zero wait states, rsp_valid is seen in cycle N+3. Each PREADY-low cycle adds one cycle.
- APB_PADDR, APB_PWRITE and APB_PWDATA keep their last values after a transfer. Only PSEL/PENABLE return to 0.
- PSLVERR is sampled only when PSEL & PENABLE & PREADY are all 1; it is ignored at all other times.
- cmd_* inputs are ignored outside IDLE.

Optional Feature:
APB_MASTER_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ACCESS and increments on each ACCESS cycle with APB_PREADY = 0.
  - When the count reaches TIMEOUT_CYCLES with PREADY still 0: abort the transfer (PSEL/PENABLE → 0), set rsp_err = 1, rsp_rdata = 0, rsp_valid = 1, and go to RESP.
  - A PREADY = 1 arriving on the same cycle as the limit takes priority and completes normally.
- Undefined: no counter is built, and the block waits indefinitely in ACCESS.

Test Plan:
1. Write, no wait states.
   - Stimulus: cmd write addr = 0x1, wdata = 0xA5A5_0F0F, strb = 0xF, PREADY tied 1.
   - Response: SETUP then ACCESS with PADDR = 1, PWDATA/PSTRB as given. rsp_valid 3 cycles after accept, rsp_err = 0, rsp_rdata = 0.
2. Read with 3 wait states.
   - Stimulus: addr = 0x3, PREADY low for 3 ACCESS cycles, then PRDATA = 0x1234_5678.
   - Response: PSTRB = 0 and PADDR stable throughout. rsp_rdata = 0x1234_5678, rsp_valid at accept + 6.
3. Completer error.
   - Stimulus: PSLVERR = 1 with PREADY = 1 on a write.
   - Response: rsp_err = 1. PSLVERR = 1 driven during a wait cycle is ignored.
4. Response backpressure.
   - Stimulus: rsp_ready = 0 for 5 cycles; cmd_valid held 1 with a second command.
   - Response: rsp_* held stable, cmd_ready = 0. The second command is accepted only after rsp_ready and an IDLE cycle.
5. Reset mid-ACCESS.
   - Stimulus: assert APB_RESET_n low while PREADY = 0.
   - Response: PSEL/PENABLE/rsp_valid go to 0 asynchronously. cmd_ready = 1 after release, and no stale response appears.
6. Timeout (APB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES = 4).
   - Stimulus: PREADY stuck 0.
   - Response: abort after 4 wait cycles with rsp_err = 1 and rsp_rdata = 0. The same bench without the macro must still be in ACCESS after 100 cycles.
